// File: rtl/prefix_reduce_pipe_if.sv
// Request/result bus for prefix_reduce_pipe.
// Handshake: a request transfers on a rising clk edge where in_valid && in_ready.
// A result transfers on a rising edge where out_valid && out_ready. A source
// holds valid and its payload steady until the transfer. in_ready may depend
// combinationally on out_ready.
interface prefix_reduce_pipe_if #(
  parameter int WIDTH = 27,
  parameter int SELW  = 5,
  parameter int CNTW  = 8
) ();

  // Request side
  logic             in_valid;
  logic             in_ready;
  logic [SELW-1:0]  sel;
  logic [1:0]       mode;
  logic [WIDTH-1:0] data;

  // Result side
  logic             out_valid;
  logic             out_ready;
  logic             o;
  logic             oor;

  // Status
  logic [CNTW-1:0]  err_cnt;

  // Environment side: issues requests and consumes results
  modport master (
    output in_valid, sel, mode, data, out_ready,
    input  in_ready, out_valid, o, oor, err_cnt
  );

  // Block side: accepts requests and produces results
  modport slave (
    input  in_valid, sel, mode, data, out_ready,
    output in_ready, out_valid, o, oor, err_cnt
  );

endinterface

// File: rtl/prefix_reduce_pipe.sv
// Two-stage prefix-reduction selector.
// Stage 1 captures sel/mode/data. Stage 2 reduces data[sel-1:0] with OR, AND or
// XOR and registers the result bit. An empty prefix (sel == 0) yields 0 in
// every mode. A sel above WIDTH yields 0 with oor set. Both stages share one
// advance condition, so there is no skid buffer.
module prefix_reduce_pipe #(
  parameter int WIDTH = 27,
  parameter int SELW  = 5,
  parameter int CNTW  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  prefix_reduce_pipe_if.slave  bus
);

  typedef enum logic [1:0] {
    MODE_OR  = 2'b00,
    MODE_AND = 2'b01,
    MODE_XOR = 2'b10,
    MODE_RSV = 2'b11
  } mode_e;

  localparam logic [CNTW-1:0] CNT_MAX = '1;

  // Stage 1 registers
  logic             s1_valid;
  logic [SELW-1:0]  s1_sel;
  mode_e            s1_mode;
  logic [WIDTH-1:0] s1_data;

  // Stage 2 registers
  logic             s2_valid;
  logic             s2_o;
  logic             s2_oor;

  // Error counter
  logic [CNTW-1:0]  err_cnt_q;

  // Handshake decode
  logic             advance;
  logic             accept;
  logic             in_oor;

  // Stage 2 combinational reduction
  logic [WIDTH-1:0] mask;
  logic             red_or;
  logic             red_and;
  logic             red_xor;
  logic             s1_oor;
  logic             s1_empty;
  logic             s1_result;

  // Both stages move together whenever the output slot is free or draining.
  assign advance = !s2_valid || bus.out_ready;

  // Stage 1 can take a new request if empty, or if it empties this cycle.
  assign bus.in_ready = !s1_valid || advance;
  assign accept       = bus.in_valid && bus.in_ready;
  assign in_oor       = int'(bus.sel) > WIDTH;

  assign bus.out_valid = s2_valid;
  assign bus.o         = s2_o;
  assign bus.oor       = s2_oor;
  assign bus.err_cnt   = err_cnt_q;

  // Build the prefix mask from the stage-1 select and reduce the operand.
  always_comb begin
    mask = '0;
    for (int i = 0; i < WIDTH; i++) begin
      mask[i] = int'(s1_sel) > i;
    end
    red_or   = |(s1_data & mask);
    red_and  = &(s1_data | ~mask);
    red_xor  = ^(s1_data & mask);
    s1_oor   = int'(s1_sel) > WIDTH;
    s1_empty = (s1_sel == '0);
    case (s1_mode)
      MODE_AND: s1_result = red_and;
      MODE_XOR: s1_result = red_xor;
      default:  s1_result = red_or;
    endcase
    // The AND of an empty prefix would be 1; force 0 so every mode agrees.
    // Out-of-range selects also return 0.
    if (s1_empty || s1_oor) begin
      s1_result = 1'b0;
    end
  end

  // Stage 1 capture. A push takes priority over the emptying move, so a
  // simultaneous pop and push keeps the stage occupied.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_sel   <= '0;
      s1_mode  <= MODE_OR;
      s1_data  <= '0;
    end else if (accept) begin
      s1_valid <= 1'b1;
      s1_sel   <= bus.sel;
      s1_mode  <= mode_e'(bus.mode);
      s1_data  <= bus.data;
    end else if (advance) begin
      s1_valid <= 1'b0;
    end
  end

  // Stage 2 result register. It holds while the consumer stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_o     <= 1'b0;
      s2_oor   <= 1'b0;
    end else if (advance) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_o   <= s1_result;
        s2_oor <= s1_oor;
      end
    end
  end

  // Count accepted out-of-range requests. The count saturates and never wraps.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_cnt_q <= '0;
    end else if (accept && in_oor && (err_cnt_q != CNT_MAX)) begin
      err_cnt_q <= err_cnt_q + CNTW'(1);
    end
  end

endmodule

// File: tb/tb_prefix_reduce_pipe.sv
// Directed bench for prefix_reduce_pipe. Expected result bits are written
// out by hand for each request. They are queued when a request is accepted
// and compared when the result is consumed.
module tb_prefix_reduce_pipe;

  localparam int WIDTH = 27;
  localparam int SELW  = 5;
  localparam int CNTW  = 8;

  logic clk;
  logic rst;

  prefix_reduce_pipe_if #(.WIDTH(WIDTH), .SELW(SELW), .CNTW(CNTW)) bus ();

  prefix_reduce_pipe #(.WIDTH(WIDTH), .SELW(SELW), .CNTW(CNTW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard state: expected {oor, o} per accepted request
  logic [1:0] exp_q[$];
  logic [1:0] cur_exp;
  logic       last_acc;
  int         n_vec;
  int         n_fail;
  int         stall_cnt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle, entered and left at a falling edge. It sees the result
  // consumed and the request accepted on the coming rising edge.
  task automatic tick();
    logic [1:0] e;
    #1;
    if (bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_result", 32'(bus.out_valid), 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("result", 32'({bus.oor, bus.o}), 32'(e));
      end
    end
    last_acc = bus.in_valid && bus.in_ready;
    if (last_acc) exp_q.push_back(cur_exp);
    @(posedge clk);
    @(negedge clk);
  endtask

  // Present one request and hold it until it is accepted. The wait is bounded.
  task automatic push_req(input logic [SELW-1:0] s, input logic [1:0] m,
                          input logic [WIDTH-1:0] d, input logic [1:0] e);
    int n;
    bus.in_valid = 1'b1;
    bus.sel      = s;
    bus.mode     = m;
    bus.data     = d;
    cur_exp      = e;
    n = 0;
    do begin
      tick();
      n++;
    end while (!last_acc && n < 50);
    if (!last_acc) check("accept_timeout", 32'(last_acc), 32'd1);
    if (n > 1) stall_cnt++;
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
  endtask

  // Consume every outstanding result. The wait is bounded.
  task automatic drain();
    int n;
    idle();
    bus.out_ready = 1'b1;
    n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      tick();
      n++;
    end
    check("drain_left", 32'(exp_q.size()), 32'd0);
    #1;
    check("no_extra_result", 32'(bus.out_valid), 32'd0);
  endtask

  // Directed sequence
  initial begin
    n_vec = 0;
    n_fail = 0;
    stall_cnt = 0;
    cur_exp = '0;
    last_acc = 1'b0;
    rst = 1'b1;
    bus.in_valid  = 1'b1;
    bus.sel       = 5'd3;
    bus.mode      = 2'b00;
    bus.data      = 27'h7FFFFFF;
    bus.out_ready = 1'b1;

    // Reset with a request pending
    repeat (3) @(negedge clk);
    #1;
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_o", 32'(bus.o), 32'd0);
    check("rst_oor", 32'(bus.oor), 32'd0);
    check("rst_err_cnt", 32'(bus.err_cnt), 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    idle();

    // First request after release: 2-cycle latency
    bus.in_valid = 1'b1;
    bus.sel = 5'd1; bus.mode = 2'b00; bus.data = 27'h0000001;
    cur_exp = 2'b01;
    tick();
    check("lat_accepted", 32'(last_acc), 32'd1);
    idle();
    #1;
    check("lat_not_yet", 32'(bus.out_valid), 32'd0);
    tick();
    #1;
    check("lat_valid", 32'(bus.out_valid), 32'd1);
    drain();

    // Prefix sweep in OR mode, back to back
    stall_cnt = 0;
    for (int s = 0; s <= WIDTH; s++) begin
      push_req(SELW'(s), 2'b00, 27'h0000001, (s == 0) ? 2'b00 : 2'b01);
    end
    check("sweep_stalls", 32'(stall_cnt), 32'd0);
    drain();

    // Operator modes with data = 6
    push_req(5'd3, 2'b00, 27'h0000006, 2'b01);  // OR of 110
    push_req(5'd3, 2'b01, 27'h0000006, 2'b00);  // AND of 110
    push_req(5'd3, 2'b10, 27'h0000006, 2'b00);  // XOR of 110
    push_req(5'd2, 2'b01, 27'h0000006, 2'b00);  // AND of 10
    push_req(5'd2, 2'b10, 27'h0000006, 2'b01);  // XOR of 10
    push_req(5'd0, 2'b01, 27'h0000006, 2'b00);  // AND of empty prefix
    push_req(5'd3, 2'b11, 27'h0000006, 2'b01);  // reserved behaves as OR
    push_req(5'd4, 2'b10, 27'h000000B, 2'b01);  // XOR of 1011
    push_req(5'd5, 2'b01, 27'h000001F, 2'b01);  // AND of 11111
    push_req(5'd6, 2'b01, 27'h000001F, 2'b00);  // AND of 011111
    push_req(5'd27, 2'b01, 27'h7FFFFFF, 2'b01); // AND across the full width
    push_req(5'd27, 2'b10, 27'h4000000, 2'b01); // XOR sees the top bit
    push_req(5'd26, 2'b00, 27'h4000000, 2'b00); // OR stops below the top bit
    drain();

    // Out-of-range selects
    check("oor_cnt_before", 32'(bus.err_cnt), 32'd0);
    push_req(5'd28, 2'b00, 27'h7FFFFFF, 2'b10);
    push_req(5'd31, 2'b01, 27'h7FFFFFF, 2'b10);
    drain();
    check("oor_cnt_two", 32'(bus.err_cnt), 32'd2);

    // Backpressure: two accepted, the third blocked, the held output stable
    bus.out_ready = 1'b0;
    push_req(5'd1, 2'b00, 27'h0000001, 2'b01);  // A
    push_req(5'd1, 2'b00, 27'h0000000, 2'b00);  // B
    bus.in_valid = 1'b1;
    bus.sel = 5'd2; bus.mode = 2'b10; bus.data = 27'h0000002;  // C
    cur_exp = 2'b01;
    #1;
    check("bp_full_in_ready", 32'(bus.in_ready), 32'd0);
    check("bp_out_valid", 32'(bus.out_valid), 32'd1);
    check("bp_o_hold", 32'({bus.oor, bus.o}), 32'd1);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("bp_blocked", 32'(last_acc), 32'd0);
      check("bp_o_stable", 32'({bus.oor, bus.o}), 32'd1);
    end
    bus.out_ready = 1'b1;
    push_req(5'd2, 2'b10, 27'h0000002, 2'b01);
    drain();

    // Saturation of the error counter: 300 out-of-range requests
    for (int k = 0; k < 253; k++) begin
      push_req(SELW'(28 + (k % 4)), 2'b00, 27'h7FFFFFF, 2'b10);
    end
    check("sat_reach", 32'(bus.err_cnt), 32'd255);
    for (int k = 0; k < 47; k++) begin
      push_req(SELW'(28 + (k % 4)), 2'b10, 27'h0000001, 2'b10);
    end
    check("sat_hold", 32'(bus.err_cnt), 32'd255);
    drain();

    // Reset mid-stream discards in-flight requests
    bus.out_ready = 1'b0;
    push_req(5'd1, 2'b00, 27'h0000001, 2'b01);
    push_req(5'd2, 2'b00, 27'h0000002, 2'b01);
    #2;
    rst = 1'b1;
    #1;
    check("mrst_out_valid", 32'(bus.out_valid), 32'd0);
    check("mrst_o", 32'(bus.o), 32'd0);
    check("mrst_err_cnt", 32'(bus.err_cnt), 32'd0);
    check("mrst_in_ready", 32'(bus.in_ready), 32'd1);
    exp_q.delete();
    idle();
    @(negedge clk);
    rst = 1'b0;
    bus.out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("mrst_silent", 32'(bus.out_valid), 32'd0);
    end
    push_req(5'd4, 2'b10, 27'h000000B, 2'b01);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
